// File: rtl/imc_pkg.sv
// imc_pkg: shared definitions for the compute-in-memory array sequencer.
// Holds the command opcode encoding, the sequencer state enum, the phase
// down-counter width and small helpers that turn phase lengths into
// counter load values.
package imc_pkg;

    // Command opcodes as presented on cmd_op
    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_MAC   = 2'd3
    } op_t;

    // Sequencer phases; every operation walks a subset of these
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_WR    = 3'd2,
        S_EVAL  = 3'd3,
        S_SENSE = 3'd4,
        S_PUSH  = 3'd5
    } state_t;

    // Width of the single phase down-counter (phases up to 256 cycles)
    localparam int CNT_W = 8;

    // Scalar array phase controls, registered together
    typedef struct packed {
        logic pre_sram;
        logic we;
        logic pre_vlsa;
        logic pre_clsa;
        logic pre_a;
        logic en;
        logic saen;
    } ctrl_t;

    // A phase of len cycles loads len-1 and ends when the counter hits zero
    function automatic logic [CNT_W-1:0] phase_load(input int len);
        return CNT_W'(len - 1);
    endfunction

    // Runtime override: a zero field falls back to the parameter default
    function automatic logic [CNT_W-1:0] pick_load(input logic [3:0] cfg, input int dflt);
        if (cfg == 4'd0) begin
            return CNT_W'(dflt - 1);
        end
        return CNT_W'(cfg) - 1'b1;
    endfunction

endpackage

// File: rtl/imc_result_fifo.sv
// imc_result_fifo: small parametrised result FIFO with full/empty flags.
// A push into a full FIFO is accepted when a pop happens in the same cycle,
// because the popped slot is the one being overwritten. A pop while empty
// is ignored. Storage is reset so the head reads as zero after reset.
module imc_result_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage, cleared on reset so the visible head starts at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/imc_array_sequencer.sv
// imc_array_sequencer: phase sequencer for the SRAM compute-in-memory array.
// Runs WRITE / READ / MAC commands through PRE, WR, EVAL, SENSE and PUSH
// phases, drives the analog control pins from registers only, and queues
// READ/MAC results in imc_result_fifo.
// Optional build macro IMC_RUNTIME_TIMING_EN adds cfg_t_pre/cfg_t_eval/
// cfg_t_sa inputs that override the precharge, evaluation and sense lengths
// per command (0 keeps the parameter value).
module imc_array_sequencer
    import imc_pkg::*;
#(
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int ADC_BITS  = 4,
    parameter int T_PRE     = 2,
    parameter int T_WR      = 2,
    parameter int T_EVAL    = 3,
    parameter int T_SA      = 1,
    parameter int OUT_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [$clog2(ROWS)-1:0]    cmd_row,
    input  logic [COLS-1:0]            cmd_wdata,
    input  logic [ROWS-1:0]            cmd_act,
    input  logic [ROWS-1:0]            cmd_mask,
    output logic                       PRE_SRAM,
    output logic                       WE,
    output logic                       PRE_VLSA,
    output logic                       PRE_CLSA,
    output logic                       PRE_A,
    output logic                       EN,
    output logic                       SAEN,
    output logic [ROWS-1:0]            WWL,
    output logic [ROWS-1:0]            RWL,
    output logic [ROWS-1:0]            RWLB,
    output logic [COLS-1:0]            Din,
    input  logic [COLS-1:0]            SA_OUT,
    input  logic [COLS*ADC_BITS-1:0]   adc_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [COLS*ADC_BITS-1:0]   res_data,
    output logic                       res_full,
    output logic                       res_empty,
    output logic                       busy,
    output logic                       err
`ifdef IMC_RUNTIME_TIMING_EN
    ,
    input  logic [3:0]                 cfg_t_pre,
    input  logic [3:0]                 cfg_t_eval,
    input  logic [3:0]                 cfg_t_sa
`endif
);

    localparam int RW    = $clog2(ROWS);
    localparam int RES_W = COLS * ADC_BITS;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    op_t               op_q;
    op_t               op_eff;
    logic [ROWS-1:0]   wl_q;
    logic [ROWS-1:0]   act_q;
    logic [ROWS-1:0]   mask_q;
    logic [COLS-1:0]   wdata_q;
    logic              row_bad_q;
    logic [CNT_W-1:0]  eval_load_q;
    logic [CNT_W-1:0]  sa_load_q;
    logic [RES_W-1:0]  result_q;

    logic [CNT_W-1:0]  pre_load_in;
    logic [CNT_W-1:0]  eval_load_in;
    logic [CNT_W-1:0]  sa_load_in;

    logic              accept;
    logic              row_bad_in;
    logic              row_used_in;
    logic              push_ok;
    logic              fifo_full;
    logic              fifo_empty;

    ctrl_t             ctrl_nxt;
    ctrl_t             ctrl_q;
    logic [ROWS-1:0]   wwl_nxt;
    logic [ROWS-1:0]   rwl_nxt;
    logic [ROWS-1:0]   rwlb_nxt;
    logic [COLS-1:0]   din_nxt;

`ifdef IMC_RUNTIME_TIMING_EN
    assign pre_load_in  = pick_load(cfg_t_pre,  T_PRE);
    assign eval_load_in = pick_load(cfg_t_eval, T_EVAL);
    assign sa_load_in   = pick_load(cfg_t_sa,   T_SA);
`else
    assign pre_load_in  = phase_load(T_PRE);
    assign eval_load_in = phase_load(T_EVAL);
    assign sa_load_in   = phase_load(T_SA);
`endif

    assign accept      = cmd_valid && (state == S_IDLE);
    assign op_eff      = accept ? op_t'(cmd_op) : op_q;
    assign row_bad_in  = ({1'b0, cmd_row} >= (RW+1)'(ROWS));
    assign row_used_in = (op_t'(cmd_op) == OP_WRITE) || (op_t'(cmd_op) == OP_READ);
    assign push_ok     = !fifo_full || res_ready;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign res_valid = !fifo_empty;
    assign res_full  = fifo_full;
    assign res_empty = fifo_empty;

    assign PRE_SRAM = ctrl_q.pre_sram;
    assign WE       = ctrl_q.we;
    assign PRE_VLSA = ctrl_q.pre_vlsa;
    assign PRE_CLSA = ctrl_q.pre_clsa;
    assign PRE_A    = ctrl_q.pre_a;
    assign EN       = ctrl_q.en;
    assign SAEN     = ctrl_q.saen;

    // Phase walk: each phase loads the down-counter and advances at zero
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (cmd_valid && (op_t'(cmd_op) != OP_NOP)) begin
                    state_nxt = S_PRE;
                    cnt_nxt   = pre_load_in;
                end
            end
            S_PRE: begin
                if (cnt == '0) begin
                    if (op_q == OP_WRITE) begin
                        state_nxt = S_WR;
                        cnt_nxt   = phase_load(T_WR);
                    end else begin
                        state_nxt = S_EVAL;
                        cnt_nxt   = eval_load_q;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_WR: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_EVAL: begin
                if (cnt == '0) begin
                    state_nxt = S_SENSE;
                    cnt_nxt   = sa_load_q;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_SENSE: begin
                if (cnt == '0) begin
                    state_nxt = S_PUSH;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_PUSH: begin
                if (push_ok) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Array pin values for the upcoming phase, so the pins register in step with state
    always_comb begin
        ctrl_nxt = '0;
        wwl_nxt  = '0;
        rwl_nxt  = '0;
        rwlb_nxt = '0;
        din_nxt  = '0;
        case (state_nxt)
            S_PRE: begin
                case (op_eff)
                    OP_WRITE: begin
                        ctrl_nxt.pre_sram = 1'b1;
                    end
                    OP_READ: begin
                        ctrl_nxt.pre_sram = 1'b1;
                        ctrl_nxt.pre_vlsa = 1'b1;
                    end
                    OP_MAC: begin
                        ctrl_nxt.pre_clsa = 1'b1;
                        ctrl_nxt.pre_a    = 1'b1;
                    end
                    default: begin
                        ctrl_nxt = '0;
                    end
                endcase
            end
            S_WR: begin
                ctrl_nxt.we = 1'b1;
                wwl_nxt     = wl_q;
                din_nxt     = wdata_q;
            end
            S_EVAL: begin
                ctrl_nxt.en = 1'b1;
                if (op_q == OP_READ) begin
                    rwl_nxt = wl_q;
                end else begin
                    rwl_nxt  = mask_q & act_q;
                    rwlb_nxt = mask_q & ~act_q;
                end
            end
            S_SENSE: begin
                ctrl_nxt.saen = 1'b1;
                ctrl_nxt.en   = (op_q == OP_READ);
            end
            default: begin
                ctrl_nxt = '0;
            end
        endcase
    end

    // State and phase counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Latch the command on accept; an out-of-range row decodes to no wordline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= OP_NOP;
            wl_q        <= '0;
            act_q       <= '0;
            mask_q      <= '0;
            wdata_q     <= '0;
            row_bad_q   <= 1'b0;
            eval_load_q <= '0;
            sa_load_q   <= '0;
        end else if (accept) begin
            op_q        <= op_t'(cmd_op);
            wl_q        <= row_bad_in ? '0 : (ROWS'(1) << cmd_row);
            act_q       <= cmd_act;
            mask_q      <= cmd_mask;
            wdata_q     <= cmd_wdata;
            row_bad_q   <= row_bad_in;
            eval_load_q <= eval_load_in;
            sa_load_q   <= sa_load_in;
        end
    end

    // Registered array pins; reset clears them asynchronously, dropping every wordline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= '0;
            WWL    <= '0;
            RWL    <= '0;
            RWLB   <= '0;
            Din    <= '0;
        end else begin
            ctrl_q <= ctrl_nxt;
            WWL    <= wwl_nxt;
            RWL    <= rwl_nxt;
            RWLB   <= rwlb_nxt;
            Din    <= din_nxt;
        end
    end

    // Capture the sense-amp or ADC word on the final SENSE cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
        end else if ((state == S_SENSE) && (cnt == '0)) begin
            if (op_q == OP_READ) begin
                result_q <= row_bad_q ? '0 : RES_W'(SA_OUT);
            end else begin
                result_q <= adc_out;
            end
        end
    end

    // Sticky error for a WRITE/READ aimed past the last wordline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (accept && row_used_in && row_bad_in) begin
            err <= 1'b1;
        end
    end

    imc_result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (OUT_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (state == S_PUSH),
        .wdata   (result_q),
        .pop     (res_ready),
        .rdata   (res_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_imc_array_sequencer.sv
// tb_imc_array_sequencer: randomized self-checking bench for imc_array_sequencer.
// The DUT is built with ROWS=12 so out-of-range rows can be exercised.
// Expected pin values per cycle come from the phase timeline of each command
// (cycle index after accept), and results are tracked in a queue model.
module tb_imc_array_sequencer;

    localparam int ROWS     = 12;
    localparam int COLS     = 16;
    localparam int ADC_BITS = 4;
    localparam int TP       = 2;
    localparam int TW       = 2;
    localparam int TE       = 3;
    localparam int TS       = 1;
    localparam int DEPTH    = 4;
    localparam int RW       = $clog2(ROWS);
    localparam int DW       = COLS * ADC_BITS;

    localparam logic [8:0] C_PRE_SRAM = 9'h100;
    localparam logic [8:0] C_WE       = 9'h080;
    localparam logic [8:0] C_VLSA     = 9'h040;
    localparam logic [8:0] C_CLSA     = 9'h020;
    localparam logic [8:0] C_PREA     = 9'h010;
    localparam logic [8:0] C_EN       = 9'h008;
    localparam logic [8:0] C_SAEN     = 9'h004;
    localparam logic [8:0] C_BUSY     = 9'h002;
    localparam logic [8:0] C_READY    = 9'h001;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_op = '0;
    logic [RW-1:0]   cmd_row = '0;
    logic [COLS-1:0] cmd_wdata = '0;
    logic [ROWS-1:0] cmd_act = '0;
    logic [ROWS-1:0] cmd_mask = '0;
    logic            PRE_SRAM, WE, PRE_VLSA, PRE_CLSA, PRE_A, EN, SAEN;
    logic [ROWS-1:0] WWL, RWL, RWLB;
    logic [COLS-1:0] Din;
    logic [COLS-1:0] SA_OUT = '0;
    logic [DW-1:0]   adc_out = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [DW-1:0]   res_data;
    logic            res_full, res_empty, busy, err;

    int              checks = 0;
    int              failures = 0;
    logic [DW-1:0]   model_q[$];
    bit              err_model = 1'b0;

    always #5 clk = ~clk;

    imc_array_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .ADC_BITS(ADC_BITS), .T_PRE(TP), .T_WR(TW),
        .T_EVAL(TE), .T_SA(TS), .OUT_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_wdata(cmd_wdata), .cmd_act(cmd_act),
        .cmd_mask(cmd_mask), .PRE_SRAM(PRE_SRAM), .WE(WE), .PRE_VLSA(PRE_VLSA),
        .PRE_CLSA(PRE_CLSA), .PRE_A(PRE_A), .EN(EN), .SAEN(SAEN), .WWL(WWL), .RWL(RWL),
        .RWLB(RWLB), .Din(Din), .SA_OUT(SA_OUT), .adc_out(adc_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_full(res_full),
        .res_empty(res_empty), .busy(busy), .err(err)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Array pins plus busy/cmd_ready against the expected phase values
    task automatic checkArray(input logic [8:0] ectrl, input logic [ROWS-1:0] ewwl,
                              input logic [ROWS-1:0] erwl, input logic [ROWS-1:0] erwlb,
                              input logic [COLS-1:0] edin);
        checkOutput("ctrl", {PRE_SRAM, WE, PRE_VLSA, PRE_CLSA, PRE_A, EN, SAEN, busy, cmd_ready}, ectrl);
        checkOutput("wwl", WWL, ewwl);
        checkOutput("rwl", RWL, erwl);
        checkOutput("rwlb", RWLB, erwlb);
        checkOutput("din", Din, edin);
    endtask

    // Result FIFO flags/head and the sticky error against the models
    task automatic checkCommon();
        checkOutput("res_valid", res_valid, model_q.size() > 0);
        checkOutput("res_empty", res_empty, model_q.size() == 0);
        checkOutput("res_full", res_full, model_q.size() == DEPTH);
        if (model_q.size() > 0) checkOutput("res_data", res_data, model_q[0]);
        checkOutput("err", err, err_model);
    endtask

    // One clock: model pops (res_ready) before an optional push, then return at the negedge
    task automatic tick(input bit do_push, input logic [DW-1:0] val);
        @(posedge clk);
        if (res_ready && model_q.size() > 0) void'(model_q.pop_front());
        if (do_push) model_q.push_back(val);
        @(negedge clk);
    endtask

    // Issue one command and check every cycle until the sequencer is idle again
    task automatic applyStimulus(input logic [1:0] op, input logic [RW-1:0] row,
                                 input logic [COLS-1:0] wd, input logic [ROWS-1:0] act,
                                 input logic [ROWS-1:0] mask, input logic [COLS-1:0] sa,
                                 input logic [DW-1:0] adc, input int pop_pct);
        logic [ROWS-1:0] oh;
        logic [DW-1:0]   result;
        logic [8:0]      ectrl;
        logic [ROWS-1:0] ewwl, erwl, erwlb;
        logic [COLS-1:0] edin;
        bit              pushed;
        bit              will_push;
        int              push_k;
        pushed = 1'b0;
        push_k = TP + TE + TS + 1;
        oh = '0;
        if (int'(row) < ROWS) oh[row] = 1'b1;
        if (op == 2'd2) result = (int'(row) < ROWS) ? DW'(sa) : '0;
        else result = adc;
        checkOutput("ready_before", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_wdata = wd;
        cmd_act = act; cmd_mask = mask; SA_OUT = sa; adc_out = adc;
        res_ready = ($urandom_range(99) < pop_pct);
        tick(1'b0, '0);
        if ((op == 2'd1 || op == 2'd2) && int'(row) >= ROWS) err_model = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom_range(3)); cmd_row = RW'($urandom_range(15));
        cmd_wdata = COLS'($urandom); cmd_act = ROWS'($urandom); cmd_mask = ROWS'($urandom);
        for (int k = 1; k < 64; k++) begin
            if (op == 2'd0 || pushed || (op == 2'd1 && k > TP + TW)) break;
            ectrl = C_BUSY; ewwl = '0; erwl = '0; erwlb = '0; edin = '0;
            will_push = 1'b0;
            if (k <= TP) begin
                if (op == 2'd1) ectrl |= C_PRE_SRAM;
                else if (op == 2'd2) ectrl |= C_PRE_SRAM | C_VLSA;
                else ectrl |= C_CLSA | C_PREA;
            end else if (op == 2'd1) begin
                ectrl |= C_WE; ewwl = oh; edin = wd;
            end else if (k <= TP + TE) begin
                ectrl |= C_EN;
                if (op == 2'd2) erwl = oh;
                else begin erwl = mask & act; erwlb = mask & ~act; end
            end else if (k <= TP + TE + TS) begin
                ectrl |= (op == 2'd2) ? (C_SAEN | C_EN) : C_SAEN;
            end
            checkArray(ectrl, ewwl, erwl, erwlb, edin);
            checkCommon();
            res_ready = ($urandom_range(99) < pop_pct);
            if (k >= push_k) begin
                if (k - push_k >= 3) res_ready = 1'b1;
                will_push = (model_q.size() < DEPTH) || res_ready;
            end
            tick(will_push, result);
            pushed = will_push;
        end
        checkArray(C_READY, '0, '0, '0, '0);
        checkCommon();
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test-plan cases, randomized traffic, back-pressure and reset mid-MAC
    initial begin
        #1 reset_n = 1'b0;
        #11;
        checkArray(C_READY, '0, '0, '0, '0);
        checkCommon();
        checkOutput("rst_res_data", res_data, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed WRITE / READ / MAC");
        applyStimulus(2'd1, 4'd5, 16'hA5C3, '0, '0, '0, '0, 0);
        applyStimulus(2'd2, 4'd3, '0, '0, '0, 16'h1234, '0, 0);
        applyStimulus(2'd3, '0, '0, 12'h0FF, 12'hF0F, '0, 64'hFEDC_BA98_7654_3210, 0);

        $display("[TB] out-of-range row then valid READ");
        applyStimulus(2'd2, 4'd13, '0, '0, '0, 16'hFFFF, '0, 0);
        checkOutput("err_sticky", err, 1'b1);
        applyStimulus(2'd2, 4'd2, '0, '0, '0, 16'hBEEF, '0, 0);

        $display("[TB] randomized commands");
        for (int n = 0; n < 40; n++) begin
            applyStimulus(2'($urandom_range(3)), RW'($urandom_range(15)), COLS'($urandom),
                          ROWS'($urandom), ROWS'($urandom), COLS'($urandom),
                          {$urandom, $urandom}, 50);
        end

        $display("[TB] FIFO back-pressure");
        res_ready = 1'b1;
        repeat (DEPTH + 1) tick(1'b0, '0);
        res_ready = 1'b0;
        checkOutput("drained", res_empty, 1'b1);
        for (int n = 0; n < 5; n++) begin
            applyStimulus(2'd3, '0, '0, ROWS'($urandom), ROWS'($urandom), '0,
                          {$urandom, $urandom}, 0);
        end
        checkOutput("full_after_stall", res_full, 1'b1);

        $display("[TB] reset during MAC evaluation");
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_act = 12'hAAA; cmd_mask = 12'hFFF;
        res_ready = 1'b0;
        tick(1'b0, '0);
        cmd_valid = 1'b0;
        repeat (TP) tick(1'b0, '0);
        checkOutput("mac_eval_rwl", RWL, 12'hAAA);
        checkOutput("mac_eval_en", EN, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_rwl", RWL, '0);
        checkOutput("rst_rwlb", RWLB, '0);
        checkOutput("rst_en", EN, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        model_q.delete();
        err_model = 1'b0;
        checkCommon();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkArray(C_READY, '0, '0, '0, '0);
        checkCommon();
        applyStimulus(2'd2, 4'd7, '0, '0, '0, 16'h5A5A, '0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
